platformnioscrc_pio_in: RTL
===========================

// Module: platformnioscrc_pio_in
// PURPOSE
//  Avalon-MM slave input PIO; read-side counterpart of the 24-bit output PIO.
//  Samples external in_port through a 2-FF synchronizer and exposes the value to the Nios II.
//  Detects per-bit edges into a sticky edge-capture register and raises a maskable level irq.
//  Sits on the Nios data master next to the output PIO; carries CRC-engine status/done flags.
// PARAMETERS
//  DW         24  width of in_port and of all data registers (1..32)
//  EDGE_TYPE  0   0 = rising, 1 = falling, 2 = any edge
//  RESET_VAL  0   reset value of synchronizer and previous-sample flops
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous active-low reset
//  address    in   2   word address of the register
//  chipselect in   1   slave select
//  write_n    in   1   active-low write strobe
//  writedata  in   32  write data
//  in_port    in   DW  asynchronous external inputs
//  readdata   out  32  read data, zero-extended above DW
//  irq        out  1   level interrupt to the Nios II
// BEHAVIOUR
//  Register map (word address):
//   0 DATA  RO   synchronized in_port (sync2); writes ignored
//   1 DIR   RO   reads 0; writes ignored
//   2 MASK  RW   irq_mask[DW-1:0]; write loads writedata[DW-1:0]
//   3 EDGE  R/W1C  edge_capture[DW-1:0]; write clears bits set in writedata
//  Bus: zero wait states, read latency 0; readdata is combinational from address;
//   chipselect not required for reads; write takes effect when chipselect && !write_n.
//  Reset (async, reset_n = 0): sync1 = sync2 = prev = RESET_VAL; irq_mask = 0;
//   edge_capture = 0; hence irq = 0 and readdata at address 0 = RESET_VAL.
//  Pipeline: sync1 <= in_port; sync2 <= sync1; prev <= sync2, every clk.
//  Edge detect (combinational): rise = sync2 & ~prev; fall = ~sync2 & prev;
//   edge = rise | fall | (rise ^ fall), selected by EDGE_TYPE.
//  Capture: edge_capture <= (edge_capture & ~clr) | edge, where clr = writedata[DW-1:0]
//   on a write to address 3, else 0. A simultaneous new edge and clear on the
//   same bit leaves the bit set (set wins).
//  Latency: in_port change before clock edge k -> DATA readable after edge k+1;
//   edge_capture bit set after edge k+2; irq asserted in the same cycle.
//  irq = |(edge_capture & irq_mask), combinational from registers, no glitch
//   sources; irq stays high until every masked captured bit is cleared or masked.
//  Masking does not affect capture: edges on masked bits are still recorded.
//  Pulses shorter than one clk period may be missed; no pulse stretching.
//  Address 1 and unused readdata bits [31:DW] read as 0.
//  Reset mid-operation clears captures and mask immediately; no irq after release
//   until a new edge is detected post-reset (prev reloads RESET_VAL).
// STRUCTURE
//  Package platformnioscrc_pio_pkg: ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2,
//   ADDR_EDGE=3; EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
//  Sub-module platformnioscrc_sync2 #(W, RESET_VAL): 2-FF vector synchronizer,
//   async active-low reset; reusable by other input peripherals.
//  Top holds prev register, edge logic, mask/capture registers, read mux.
// TESTING
//  1 Reset: hold reset_n=0, in_port=24'hFFFFFF -> readdata=0 at all addresses, irq=0.
//  2 Sync latency: in_port 0->24'h00A5A5 before edge k -> DATA reads 0 at k+1 only
//    before it, reads 24'h00A5A5 after edge k+1; EDGE_TYPE=0 -> EDGE=24'h00A5A5 after k+2.
//  3 Mask/irq: MASK=24'h000001, rise on bit 4 -> irq=0; rise on bit 0 -> irq=1
//    in the capture cycle; write EDGE=24'h000001 -> irq=0 next cycle, EDGE bit 4 still 1.
//  4 Set-wins: W1C of bit 0 in the same cycle bit 0 edge is detected -> EDGE bit 0 =1.
//  5 EDGE_TYPE=1 and 2: pulse bit 7 high 3 cycles -> falling build captures only on
//    1->0; any-edge build captures on both; write of DIR 32'hFFFFFFFF -> DIR still 0.
//  6 Reset mid-op: EDGE=24'hFF0000, MASK=24'hFFFFFF, irq=1, assert reset_n for 1 cycle
//    -> irq=0 and EDGE=0, MASK=0 immediately (asynchronously) and after release.

Source files
------------

// File: rtl/platformnioscrc_pio_pkg.sv
// Shared constants for the Nios II input PIO.
//   Register word addresses: DATA, DIR, MASK, EDGE.
//   Edge-detect selector values for the EDGE_TYPE parameter.
package platformnioscrc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/platformnioscrc_sync2.sv
// Two-flop vector synchronizer for asynchronous inputs.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, loads RESET_VAL into both stages
//   d_i    : asynchronous input vector
//   q_o    : synchronized output (second stage)
// Each bit is synchronized independently; there is no multi-bit coherency
// guarantee, which suits independent status/flag lines.
module platformnioscrc_sync2 #(
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/platformnioscrc_pio_in.sv
// Avalon-MM slave input PIO for the Nios II data master.
// Samples in_port through a 2-FF synchronizer, records per-bit edges in a
// sticky W1C capture register and raises a maskable level interrupt.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   address    : register word address (0 DATA, 1 DIR, 2 MASK, 3 EDGE)
//   chipselect : slave select (writes only; reads are address-decoded)
//   write_n    : active-low write strobe
//   writedata  : write data, bits [DW-1:0] used
//   in_port    : asynchronous external inputs
//   readdata   : combinational read data, zero above DW
//   irq        : level interrupt = |(edge_capture & irq_mask)
module platformnioscrc_pio_in
    import platformnioscrc_pio_pkg::*;
#(
    parameter int            DW        = 24,
    parameter int            EDGE_TYPE = EDGE_RISING,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    input  logic [DW-1:0] in_port,
    output logic [31:0]   readdata,
    output logic          irq
);

    logic [DW-1:0] sync_w;
    logic [DW-1:0] prev_q;
    logic [DW-1:0] mask_q, mask_d;
    logic [DW-1:0] cap_q,  cap_d;
    logic [DW-1:0] rise_w, fall_w, edge_w, clr_w;
    logic          wr_en_w;

    platformnioscrc_sync2 #(
        .W         (DW),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (in_port),
        .q_o   (sync_w)
    );

    assign wr_en_w = chipselect && !write_n;

    assign rise_w = sync_w & ~prev_q;
    assign fall_w = ~sync_w & prev_q;

    // Unknown EDGE_TYPE values fall back to rising-edge detection.
    always_comb begin
        edge_w = rise_w;
        case (EDGE_TYPE)
            EDGE_FALLING: edge_w = fall_w;
            EDGE_ANY:     edge_w = rise_w | fall_w;
            default:      edge_w = rise_w;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        clr_w  = '0;
        if (wr_en_w && address == ADDR_MASK) mask_d = writedata[DW-1:0];
        if (wr_en_w && address == ADDR_EDGE) clr_w  = writedata[DW-1:0];
        // OR-ing the new edge after the clear makes a coincident edge win.
        cap_d = (cap_q & ~clr_w) | edge_w;
    end

    // prev reloads RESET_VAL on reset so a level already present at release
    // is seen as a fresh edge once it reaches the synchronizer output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VAL;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            prev_q <= sync_w;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    assign irq = |(cap_q & mask_q);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[DW-1:0] = sync_w;
            ADDR_MASK: readdata[DW-1:0] = mask_q;
            ADDR_EDGE: readdata[DW-1:0] = cap_q;
            default:   readdata         = '0;
        endcase
    end

endmodule
